ddr_chroma_line_fetcher: RTL

Fetches one line of planar chroma (U or V) from DDR as 64-bit bursts and writes it into the downstream chroma line buffer, which replays each line twice for vertical doubling. A new burst is issued only on even output lines; odd lines reuse buffered data and complete without DDR traffic. Runs entirely in the `clk_in` domain, between the FMV DDR arbiter port and the chroma line buffer write side.

---
 rtl/fmv_ddr_pkg.sv | 9 +
 rtl/ddr_chroma_line_fetcher.sv | 136 +++++++++++++
 2 files changed

// File: rtl/fmv_ddr_pkg.sv
// fmv_ddr_pkg: shared DDR fetcher constants, state type and burst clamp helper.
package fmv_ddr_pkg;
  localparam int DDR_ADDR_W = 29;
  localparam int DDR_MAX_WORDS = 32;
  typedef enum logic [1:0] {IDLE, REQ, DATA} fetch_state_e;
  function automatic logic [7:0] clamp_burst(input logic [5:0] w, input int max_w);
    return ({2'b00, w} > 8'(max_w)) ? 8'(max_w) : {2'b00, w};
  endfunction
endpackage

// File: rtl/ddr_chroma_line_fetcher.sv
// ddr_chroma_line_fetcher: fetches one chroma line per even output line from DDR into the line buffer.
module ddr_chroma_line_fetcher
  import fmv_ddr_pkg::*;
#(
  parameter int ADDR_W = DDR_ADDR_W,
  parameter int MAX_WORDS = DDR_MAX_WORDS
) (
  input  logic              clk_in,
  input  logic              reset,
  input  logic              start_frame,
  input  logic              line_req,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] stride,
  input  logic [5:0]        width_words,
  output logic [ADDR_W-1:0] ddr_addr,
  output logic [7:0]        ddr_burstcnt,
  output logic              ddr_rd,
  input  logic              ddr_busy,
  input  logic [63:0]       ddr_dout,
  input  logic              ddr_dout_ready,
  output logic              buf_reset,
  output logic [63:0]       buf_wdata,
  output logic              buf_we,
  output logic              line_ready,
  output logic              overrun
);
  fetch_state_e state_q, state_d;
  logic [ADDR_W-1:0] cur_addr_q, cur_addr_d, ddr_addr_q, ddr_addr_d, pend_base_q, pend_base_d;
  logic [15:0] line_cnt_q, line_cnt_d;
  logic [7:0] beats_q, beats_d, burstcnt_q, burstcnt_d;
  logic [63:0] wdata_q, wdata_d;
  logic rd_q, rd_d, brst_q, brst_d, we_q, we_d, lr_q, lr_d, ov_q, ov_d, pend_q, pend_d;
  logic [15:0] lc_eff;
  logic [ADDR_W-1:0] cur_eff;
  always_comb begin
    state_d = state_q;
    cur_addr_d = cur_addr_q;
    ddr_addr_d = ddr_addr_q;
    pend_base_d = pend_base_q;
    line_cnt_d = line_cnt_q;
    beats_d = beats_q;
    burstcnt_d = burstcnt_q;
    wdata_d = wdata_q;
    rd_d = rd_q;
    brst_d = 1'b0;
    we_d = 1'b0;
    lr_d = 1'b0;
    ov_d = ov_q;
    pend_d = pend_q;
    // A frame restart in the same IDLE cycle as a request makes that request line 0.
    lc_eff = start_frame ? 16'd0 : line_cnt_q;
    cur_eff = start_frame ? base_addr : cur_addr_q;
    if (state_q != IDLE) begin
      ov_d = ov_q | line_req;
      pend_d = pend_q | start_frame;
      pend_base_d = start_frame ? base_addr : pend_base_q;
    end
    case (state_q)
      IDLE: begin
        cur_addr_d = cur_eff;
        ov_d = start_frame ? 1'b0 : ov_q;
        line_cnt_d = line_req ? lc_eff + 16'd1 : lc_eff;
        if (line_req && !lc_eff[0] && width_words != 6'd0) begin
          brst_d = 1'b1;
          rd_d = 1'b1;
          ddr_addr_d = cur_eff;
          burstcnt_d = clamp_burst(width_words, MAX_WORDS);
          beats_d = 8'd0;
          state_d = REQ;
        end else begin
          lr_d = line_req;
        end
      end
      REQ: begin
        rd_d = ddr_busy;
        state_d = ddr_busy ? REQ : DATA;
      end
      default: begin
        if (ddr_dout_ready) begin
          we_d = 1'b1;
          wdata_d = ddr_dout;
          beats_d = beats_q + 8'd1;
          if (beats_q + 8'd1 == burstcnt_q) begin
            lr_d = 1'b1;
            state_d = IDLE;
            cur_addr_d = pend_d ? pend_base_d : cur_addr_q + stride;
            line_cnt_d = pend_d ? 16'd0 : line_cnt_q;
            ov_d = pend_d ? 1'b0 : ov_d;
            pend_d = 1'b0;
          end
        end
      end
    endcase
  end
  always_ff @(posedge clk_in) begin
    if (reset) begin
      state_q <= IDLE;
      cur_addr_q <= '0;
      ddr_addr_q <= '0;
      pend_base_q <= '0;
      line_cnt_q <= '0;
      beats_q <= '0;
      burstcnt_q <= '0;
      wdata_q <= '0;
      rd_q <= 1'b0;
      brst_q <= 1'b0;
      we_q <= 1'b0;
      lr_q <= 1'b0;
      ov_q <= 1'b0;
      pend_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cur_addr_q <= cur_addr_d;
      ddr_addr_q <= ddr_addr_d;
      pend_base_q <= pend_base_d;
      line_cnt_q <= line_cnt_d;
      beats_q <= beats_d;
      burstcnt_q <= burstcnt_d;
      wdata_q <= wdata_d;
      rd_q <= rd_d;
      brst_q <= brst_d;
      we_q <= we_d;
      lr_q <= lr_d;
      ov_q <= ov_d;
      pend_q <= pend_d;
    end
  end
  assign ddr_addr = ddr_addr_q;
  assign ddr_burstcnt = burstcnt_q;
  assign ddr_rd = rd_q;
  assign buf_reset = brst_q;
  assign buf_wdata = wdata_q;
  assign buf_we = we_q;
  assign line_ready = lr_q;
  assign overrun = ov_q;
endmodule
